// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction memory read port,
// captures each response one cycle after issue into a small {pc, instr} FIFO and
// presents the FIFO head to decode over valid/ready. Redirects flush all younger state.
module ifu_fetch #(
    parameter logic [63:0] RESET_PC   = 64'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OccW = CntW + 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(FIFO_DEPTH);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {StEmpty, StPartial, StFull} fifo_st_e;

    logic [63:0]     pc_q, pc_d;
    logic [63:0]     issue_pc_q, issue_pc_d;
    logic            inflight_q, inflight_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    fifo_st_e        st_q, st_d;
    logic [63:0]     pc_mem_q    [FIFO_DEPTH];
    logic [63:0]     pc_mem_d    [FIFO_DEPTH];
    logic [31:0]     instr_mem_q [FIFO_DEPTH];
    logic [31:0]     instr_mem_d [FIFO_DEPTH];

    logic            pop;
    logic            push;
    logic            can_issue;
    logic [OccW-1:0] occupancy;

    // Pointer advance with wrap for depths that are not a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    // Handshake, issue and capture decisions from registered state plus inputs.
    always_comb begin
        out_valid = (st_q != StEmpty);
        pop       = out_valid & out_ready;
        // Slots already committed: buffered entries plus the response in flight,
        // minus the one leaving this cycle (pop implies count_q >= 1).
        occupancy = OccW'(count_q) + OccW'(inflight_q) - OccW'(pop);
        can_issue = (occupancy < OccW'(FIFO_DEPTH));
        // Gating with rst makes the enable fall as soon as reset asserts.
        imem_en   = rst & can_issue & ~redirect_valid;
        imem_addr = pc_q;
        push      = inflight_q & ~redirect_valid;
        out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : '0;
        out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    end

    // Next-state: PC, in-flight tracking, FIFO storage, pointers and occupancy state.
    always_comb begin
        pc_d        = pc_q;
        issue_pc_d  = issue_pc_q;
        inflight_d  = 1'b0;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;

        if (redirect_valid) begin
            pc_d     = redirect_pc & ~64'd3;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            inflight_d = imem_en;
            if (imem_en) begin
                pc_d       = pc_q + 64'd4;
                issue_pc_d = pc_q;
            end
            if (push) begin
                pc_mem_d[wr_ptr_q]    = issue_pc_q;
                instr_mem_d[wr_ptr_q] = imem_instr;
                wr_ptr_d              = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        if (count_d == '0) begin
            st_d = StEmpty;
        end else if (count_d == CntMax) begin
            st_d = StFull;
        end else begin
            st_d = StPartial;
        end
    end

    // State registers; asynchronous reset drops any in-flight response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            issue_pc_q <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            st_q       <= StEmpty;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            issue_pc_q  <= issue_pc_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            st_q        <= st_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end

    // Issue throttling must make overflow and underflow impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && (count_q == CntMax) && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(pop && (count_q == '0)));

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_ifu_fetch;

    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instr;

    int checks = 0;
    int errors = 0;

    ifu_fetch #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_en        (imem_en),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    always #5 clk = ~clk;

    // Distinct word per address so a pc/instr pairing error is visible.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: registered read, holds stale data when not enabled.
    always @(posedge clk or negedge rst) begin
        if (!rst) imem_instr <= '0;
        else if (imem_en) imem_instr <= mem_word(imem_addr);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {63'd0, act}, {63'd0, exp});
    endtask

    // Reference model: buffered pcs, one pending fetch, next fetch address.
    logic [63:0] mq[$];
    bit          m_pend;
    logic [63:0] m_pend_pc;
    logic [63:0] m_next;

    task automatic model_reset();
        mq.delete();
        m_pend    = 1'b0;
        m_pend_pc = '0;
        m_next    = RST_PC;
    endtask

    // Compare this cycle against the model at the negedge, advance the model,
    // then return just after the next posedge.
    task automatic step();
        bit          ev;
        bit          pp;
        bit          een;
        int          occ;
        @(negedge clk);
        if (!rst) begin
            chk1("rst_imem_en", imem_en, 1'b0);
            chk1("rst_out_valid", out_valid, 1'b0);
        end else begin
            ev  = (mq.size() != 0);
            pp  = ev && out_ready;
            occ = mq.size() + int'(m_pend) - int'(pp);
            een = (occ < DEPTH) && !redirect_valid;
            chk1("m_imem_en", imem_en, een);
            if (een) chk("m_imem_addr", imem_addr, m_next);
            chk1("m_out_valid", out_valid, ev);
            if (ev) begin
                chk("m_out_pc", out_pc, mq[0]);
                chk("m_out_instr", {32'd0, out_instr}, {32'd0, mem_word(mq[0])});
            end
            if (redirect_valid) begin
                mq.delete();
                m_pend = 1'b0;
                m_next = redirect_pc & ~64'd3;
            end else begin
                if (pp) void'(mq.pop_front());
                if (m_pend) mq.push_back(m_pend_pc);
                m_pend    = een;
                m_pend_pc = m_next;
                if (een) m_next = m_next + 64'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        bit          do_rst;
        bit          ready;
        bit          exp_en;
        logic [63:0] exp_addr;
        bit          exp_valid;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming from reset, then stalled decode filling the buffer and draining.
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 64'h8000_0000, 1'b0, 64'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 64'h8000_0004, 1'b0, 64'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0000};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 64'h8000_000C, 1'b1, 64'h8000_0004};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0008};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 64'h8000_0000, 1'b0, 64'h0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 64'h8000_0004, 1'b0, 64'h0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 64'h0,         1'b1, 64'h8000_0000};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 64'h0,         1'b1, 64'h8000_0000};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0000};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 64'h8000_000C, 1'b1, 64'h8000_0004};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0008};

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].do_rst) do_reset();
            out_ready = tbl[i].ready;
            #1;
            chk1("tbl_imem_en", imem_en, tbl[i].exp_en);
            if (tbl[i].exp_en) chk("tbl_imem_addr", imem_addr, tbl[i].exp_addr);
            chk1("tbl_out_valid", out_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) chk("tbl_out_pc", out_pc, tbl[i].exp_pc);
            step();
        end

        // Redirect during a capture cycle discards the response and refetches.
        out_ready = 1'b1;
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1002;
        step();
        redirect_valid = 1'b0;
        #1;
        chk1("redir_out_valid", out_valid, 1'b0);
        chk1("redir_imem_en", imem_en, 1'b1);
        chk("redir_imem_addr", imem_addr, 64'h8000_1000);
        step();
        step();
        #1;
        chk1("redir_valid2", out_valid, 1'b1);
        chk("redir_out_pc", out_pc, 64'h8000_1000);

        // Redirect held three cycles: no fetch, only the last target is used.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_1000_0000;
        #1 chk1("hold_en_a", imem_en, 1'b0);
        step();
        redirect_pc = 64'h0000_0000_2000_0001;
        #1 chk1("hold_en_b", imem_en, 1'b0);
        step();
        redirect_pc = 64'h0000_0000_3000_0003;
        #1 chk1("hold_en_c", imem_en, 1'b0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk1("hold_en_after", imem_en, 1'b1);
        chk("hold_addr_after", imem_addr, 64'h0000_0000_3000_0000);
        repeat (4) step();

        // Asynchronous reset between edges.
        #2 rst = 1'b0;
        #1;
        chk1("arst_out_valid", out_valid, 1'b0);
        chk1("arst_imem_en", imem_en, 1'b0);
        chk("arst_out_pc", out_pc, 64'h0);
        chk("arst_out_instr", {32'd0, out_instr}, 64'h0);
        model_reset();
        step();
        step();
        rst = 1'b1;
        #1;
        chk1("arst_rel_en", imem_en, 1'b1);
        chk("arst_rel_addr", imem_addr, RST_PC);
        chk1("arst_rel_valid", out_valid, 1'b0);
        step();
        step();
        #1;
        chk("arst_first_pc", out_pc, RST_PC);

        // Wrap of the 64-bit PC.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        #1 chk("wrap_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        #1 chk("wrap_addr1", imem_addr, 64'h0);
        step();
        #1 chk("wrap_pc0", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        #1 chk("wrap_pc1", out_pc, 64'h0);
        step();
        #1 chk("wrap_pc2", out_pc, 64'h4);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ((n / 200) % 3 == 2) out_ready = ($urandom_range(0, 7) == 0);
            else out_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            else
                redirect_pc = {$urandom, $urandom};
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
